// File: rtl/afg_pkg.sv
// rtl/afg_pkg.sv - shared game constants, coordinate type and enemy shot FSM states
package afg_pkg;

  localparam logic [5:0] LEVEL_START = 6'b000001;
  localparam logic [5:0] LEVEL_1     = 6'b000010;
  localparam logic [5:0] LEVEL_2     = 6'b000100;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef logic [9:0] coord_t;

  typedef enum logic {IDLE, ARMED} shot_state_t;

endpackage

// File: rtl/enemy_shot_slot.sv
// rtl/enemy_shot_slot.sv - one missile slot: spawn, fall, retire at screen bottom or on clear
module enemy_shot_slot
  import afg_pkg::*;
#(
  parameter int SHOT_SPEED = 4,
  parameter int SHOT_Y_MAX = 479
) (
  input  logic   frame_clk,
  input  logic   Reset,
  input  logic   spawn,
  input  coord_t spawn_x,
  input  coord_t spawn_y,
  input  logic   clear,
  input  logic   flush,
  output logic   active,
  output coord_t x,
  output coord_t y
);

  // One extra bit so a missile near the bottom cannot wrap back to the top.
  logic [10:0] next_y;

  assign next_y = {1'b0, y} + 11'(SHOT_SPEED);

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      active <= 1'b0;
      x      <= '0;
      y      <= '0;
    end else if (flush) begin
      active <= 1'b0;
      x      <= '0;
      y      <= '0;
    end else if (spawn) begin
      active <= 1'b1;
      x      <= spawn_x;
      y      <= spawn_y;
    end else if (active) begin
      if (clear || (next_y > 11'(SHOT_Y_MAX))) begin
        active <= 1'b0;
        y      <= '0;
      end else begin
        y <= next_y[9:0];
      end
    end
  end

endmodule

// File: rtl/enemy_shot_ctrl.sv
// rtl/enemy_shot_ctrl.sv - per-enemy missile pool: fire timer FSM, lowest-free slot allocation
module enemy_shot_ctrl
  import afg_pkg::*;
#(
  parameter int NUM_SHOTS   = 4,
  parameter int FIRE_PERIOD = 60,
  parameter int SHOT_SPEED  = 4,
  parameter int SHOT_OFFSET = 30,
  parameter int SHOT_Y_MAX  = SCREEN_H - 1,
  parameter int MIN_FIRE_Y  = 40
) (
  input  logic                    frame_clk,
  input  logic                    Reset,
  input  logic [5:0]              level,
  input  logic [5:0]              jetlevel,
  input  logic                    enemy_alive,
  input  logic [9:0]              EnemyX,
  input  logic [9:0]              EnemyY,
  input  logic [NUM_SHOTS-1:0]    shot_clear,
  output logic [NUM_SHOTS-1:0]    shot_active,
  output logic [10*NUM_SHOTS-1:0] ShotX,
  output logic [10*NUM_SHOTS-1:0] ShotY,
  output logic                    fire_strobe
);

  localparam int             TW   = $clog2(FIRE_PERIOD);
  localparam logic [TW-1:0]  TMAX = TW'(FIRE_PERIOD - 1);

  shot_state_t          state, state_nx;
  logic [TW-1:0]        timer, timer_nx;
  logic                 fire_strobe_nx;
  logic                 idle_cond, flush, any_free, fire_due, muzzle_ok;
  logic [10:0]          muzzle_y;
  logic [NUM_SHOTS-1:0] free, spawn_vec;

  assign flush     = (level == LEVEL_START) || (level != jetlevel);
  assign idle_cond = flush || !enemy_alive;

  assign muzzle_y  = {1'b0, EnemyY} + 11'(SHOT_OFFSET);
  assign muzzle_ok = (muzzle_y <= 11'(SHOT_Y_MAX));

  // Slots retiring this frame are still active here, so they cannot be reloaded on the same edge.
  assign free     = ~shot_active;
  assign any_free = |free;
  assign fire_due = (state == ARMED) && !idle_cond && (timer == TMAX) && any_free;

  // Isolate the lowest set bit of the free mask.
  assign spawn_vec = (fire_due && muzzle_ok) ? (free & (~free + NUM_SHOTS'(1))) : '0;

  always_comb begin
    state_nx       = state;
    timer_nx       = timer;
    fire_strobe_nx = 1'b0;
    case (state)
      IDLE: begin
        timer_nx = '0;
        if (!idle_cond && (EnemyY >= coord_t'(MIN_FIRE_Y))) begin
          state_nx = ARMED;
        end
      end
      ARMED: begin
        if (idle_cond) begin
          state_nx = IDLE;
          timer_nx = '0;
        end else if (fire_due) begin
          timer_nx       = '0;
          fire_strobe_nx = muzzle_ok;
        end else if (timer != TMAX) begin
          timer_nx = timer + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        timer_nx = '0;
      end
    endcase
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      timer       <= '0;
      fire_strobe <= 1'b0;
    end else begin
      state       <= state_nx;
      timer       <= timer_nx;
      fire_strobe <= fire_strobe_nx;
    end
  end

  for (genvar i = 0; i < NUM_SHOTS; i++) begin : g_slot
    enemy_shot_slot #(
      .SHOT_SPEED (SHOT_SPEED),
      .SHOT_Y_MAX (SHOT_Y_MAX)
    ) u_slot (
      .frame_clk (frame_clk),
      .Reset     (Reset),
      .spawn     (spawn_vec[i]),
      .spawn_x   (EnemyX),
      .spawn_y   (muzzle_y[9:0]),
      .clear     (shot_clear[i]),
      .flush     (flush),
      .active    (shot_active[i]),
      .x         (ShotX[10*i +: 10]),
      .y         (ShotY[10*i +: 10])
    );
  end

endmodule
